// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit-trace recorder: core-side bus structs, the
// shadow-entry layout and the buffered trace record.
package commit_trace_buffer_pkg;

    localparam int TRACE_DROP_CNT_W = 16;
    localparam int ROB_NUM_W        = 8;
    localparam logic [TRACE_DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef logic [ROB_NUM_W-1:0] trace_idx_t;

    typedef enum logic [1:0] {
        Inst_Empty  = 2'd0,
        Inst_Wait   = 2'd1,
        Inst_Issued = 2'd2,
        Inst_Done   = 2'd3
    } rob_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [5:0]  phy_dest;
        rob_state_t  state;
    } rob_entry_t;

    typedef struct packed {
        logic        valid;
        trace_idx_t  rob_entry_num;
        logic [3:0]  rf_we;
        logic [31:0] result;
    } execute_to_commit_bus_t;

    typedef struct packed {
        logic       valid;
        trace_idx_t rob_entry_num;
        logic       br_op;
        logic       predict_sucess;
    } commit_to_debug_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [5:0]  phy_dest;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        br_op;
        logic        predict_sucess;
    } debug_bus_t;

    typedef struct packed {
        debug_bus_t dbg;
        logic       wb_missing;
    } trace_rec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [5:0]  phy_dest;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        written;
    } shadow_entry_t;

    function automatic logic [TRACE_DROP_CNT_W-1:0] sat_add_drop(
        input logic [TRACE_DROP_CNT_W-1:0] cnt,
        input logic [31:0]                 inc
    );
        logic [32:0] sum;
        sum = 33'(cnt) + 33'(inc);
        return (sum > 33'(DROP_CNT_MAX)) ? DROP_CNT_MAX : sum[TRACE_DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Multi-write / single-read FIFO: up to WR_W records enter per cycle in slot
// order; the head is presented combinationally from storage.
module trace_fifo_mw #(
    parameter int  DEPTH = 8,
    parameter int  WR_W  = 2,
    parameter type rec_t = logic [7:0],
    localparam int AW    = $clog2(DEPTH),
    localparam int OCC_W = AW + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [OCC_W-1:0]   push_cnt,
    input  rec_t [WR_W-1:0]    wr_data,
    input  logic               pop,
    output logic               valid,
    output rec_t               head,
    output logic [OCC_W-1:0]   count
);
    rec_t mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [OCC_W-1:0] count_reg;
    logic             pop_eff;

    assign valid   = (count_reg != '0);
    assign count   = count_reg;
    assign pop_eff = pop && valid;
    assign head    = valid ? mem[rd_ptr_reg[AW-1:0]] : '0;

    // Storage carries no reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_W; i++) begin
            if (OCC_W'(i) < push_cnt) begin
                mem[wr_ptr_reg[AW-1:0] + AW'(i)] <= wr_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + push_cnt;
            rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, pop_eff};
            count_reg  <= count_reg + push_cnt - {{AW{1'b0}}, pop_eff};
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: shadows ROB entries with dispatch/writeback debug
// fields and streams committed records in program order through a FIFO.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int  ROB_DEPTH  = 16,
    parameter int  DISPATCH_W = 2,
    parameter int  WB_W       = 2,
    parameter int  COMMIT_W   = 2,
    parameter int  OUT_DEPTH  = 8,
    localparam int IDX_W      = $clog2(ROB_DEPTH),
    localparam int OCC_W      = $clog2(OUT_DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                flush,
    input  logic                                dispatch_fire,
    input  logic [IDX_W-1:0]                    rob_tail,
    input  rob_entry_t [DISPATCH_W-1:0]         dispatch_bus,
    input  execute_to_commit_bus_t [WB_W-1:0]   wb_bus,
    input  commit_to_debug_bus_t [COMMIT_W-1:0] commit_bus,
    output logic                                out_valid,
    input  logic                                out_ready,
    output debug_bus_t                          out_trace,
    output logic                                wb_missing,
    output logic                                overflow,
    output logic [TRACE_DROP_CNT_W-1:0]         drop_cnt,
    output logic [OCC_W-1:0]                    occupancy
);
    shadow_entry_t shadow_q [ROB_DEPTH];

    // Per entry: dispatch first, then writeback overrides the data fields.
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_shadow
        shadow_entry_t entry_reg;
        shadow_entry_t entry_next;

        always_comb begin
            entry_next = entry_reg;
            if (dispatch_fire) begin
                for (int l = 0; l < DISPATCH_W; l++) begin
                    if (IDX_W'(rob_tail + IDX_W'(l)) == IDX_W'(gi)) begin
                        entry_next.valid    = (dispatch_bus[l].state == Inst_Wait);
                        entry_next.pc       = dispatch_bus[l].pc;
                        entry_next.dest     = dispatch_bus[l].dest;
                        entry_next.phy_dest = dispatch_bus[l].phy_dest;
                        entry_next.wstrb    = '0;
                        entry_next.wdata    = '0;
                        entry_next.written  = 1'b0;
                    end
                end
            end
            for (int c = 0; c < WB_W; c++) begin
                if (wb_bus[c].valid && wb_bus[c].rob_entry_num[IDX_W-1:0] == IDX_W'(gi)) begin
                    entry_next.wstrb   = wb_bus[c].rf_we;
                    entry_next.wdata   = wb_bus[c].result;
                    entry_next.written = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn || flush) begin
                entry_reg <= '0;
            end else begin
                entry_reg <= entry_next;
            end
        end

        assign shadow_q[gi] = entry_reg;
    end

    trace_rec_t [COMMIT_W-1:0] lane_rec;
    logic [COMMIT_W-1:0]       lane_hit;

    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_lane
        logic [IDX_W-1:0] idx;
        shadow_entry_t    ent;
        trace_rec_t       rec;
        logic             written;

        assign idx = commit_bus[gi].rob_entry_num[IDX_W-1:0];
        assign ent = shadow_q[idx];

        always_comb begin
            rec.dbg.pc             = ent.pc;
            rec.dbg.dest           = ent.dest;
            rec.dbg.phy_dest       = ent.phy_dest;
            rec.dbg.wstrb          = ent.wstrb;
            rec.dbg.wdata          = ent.wdata;
            rec.dbg.br_op          = commit_bus[gi].br_op;
            rec.dbg.predict_sucess = commit_bus[gi].predict_sucess;
            written                = ent.written;
            // Same-cycle writeback bypass; the highest channel is applied last.
            for (int c = 0; c < WB_W; c++) begin
                if (wb_bus[c].valid && wb_bus[c].rob_entry_num[IDX_W-1:0] == idx) begin
                    rec.dbg.wstrb = wb_bus[c].rf_we;
                    rec.dbg.wdata = wb_bus[c].result;
                    written       = 1'b1;
                end
            end
            rec.wb_missing = !written;
        end

        assign lane_rec[gi] = rec;
        assign lane_hit[gi] = commit_bus[gi].valid && ent.valid;
    end

    // ROB numbers wider than the configured depth carry no information.
    logic unused_idx_hi;
    always_comb begin
        unused_idx_hi = 1'b0;
        for (int c = 0; c < WB_W; c++) begin
            unused_idx_hi = unused_idx_hi ^ (^(wb_bus[c].rob_entry_num >> IDX_W));
        end
        for (int l = 0; l < COMMIT_W; l++) begin
            unused_idx_hi = unused_idx_hi ^ (^(commit_bus[l].rob_entry_num >> IDX_W));
        end
    end

    trace_rec_t [COMMIT_W-1:0] push_rec;
    logic [OCC_W-1:0]          rec_cnt;
    logic [OCC_W-1:0]          free_cnt;
    logic [OCC_W-1:0]          push_cnt;
    logic [OCC_W-1:0]          drop_now;

    // Pack surviving records towards slot 0 so the lowest lanes win space.
    always_comb begin
        int pos;
        pos      = 0;
        push_rec = '0;
        for (int l = 0; l < COMMIT_W; l++) begin
            if (lane_hit[l]) begin
                push_rec[pos] = lane_rec[l];
                pos = pos + 1;
            end
        end
        rec_cnt = OCC_W'(pos);
    end

    assign free_cnt = OCC_W'(OUT_DEPTH) - occupancy;
    assign push_cnt = (rec_cnt < free_cnt) ? rec_cnt : free_cnt;
    assign drop_now = rec_cnt - push_cnt;

    logic                        overflow_reg;
    logic [TRACE_DROP_CNT_W-1:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop_now != '0) begin
            overflow_reg <= 1'b1;
            drop_cnt_reg <= sat_add_drop(drop_cnt_reg, 32'(drop_now));
        end
    end

    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

    trace_rec_t head;

    trace_fifo_mw #(
        .DEPTH (OUT_DEPTH),
        .WR_W  (COMMIT_W),
        .rec_t (trace_rec_t)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push_cnt (push_cnt),
        .wr_data  (push_rec),
        .pop      (out_ready),
        .valid    (out_valid),
        .head     (head),
        .count    (occupancy)
    );

    assign out_trace  = head.dbg;
    assign wb_missing = head.wb_missing;

endmodule
